rr_req_mux: RTL and testbench

- Arbitrated N:1 request multiplexer; sits directly downstream of the per-source request generators and feeds the single shared request channel (cache pipeline input).
- Per-input valid/ready channels carry multi-beat packets delimited by a last flag.
- Round-robin arbitration is at packet granularity: the grant is locked until the last beat is accepted.
- A registered output stage gives 1-cycle latency at full throughput.

---
 rtl/rr_req_mux_pkg.sv | 29 ++
 rtl/rr_req_mux_pick.sv | 21 ++
 rtl/rr_req_mux.sv | 103 ++++++++++
 tb/tb_rr_req_mux.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rr_req_mux_pkg.sv
// rtl/rr_req_mux_pkg.sv - shared types, defaults and helpers for the round-robin request mux
package rr_req_mux_pkg;

    localparam int RR_N_DEF = 4;
    localparam int RR_W_DEF = 32;
    localparam int RR_SW    = $clog2(RR_N_DEF);
    localparam int RR_MAX_N = 64;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    typedef struct packed {
        logic [RR_W_DEF-1:0] data;
        logic                last;
    } beat_t;

    // Input must be one-hot (or zero, which maps to index 0).
    function automatic int oh_to_idx(input logic [RR_MAX_N-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < RR_MAX_N; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_req_mux_pick.sv
// rtl/rr_req_mux_pick.sv - rr_ptr_pick: one-hot round-robin pick from a priority pointer
module rr_ptr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] rot;
    logic [N-1:0] first;

    // Rotate so the pointer lands on bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot   = N'({valid, valid} >> ptr);
        first = rot & (~rot + N'(1));
        grant = N'(({first, first} << ptr) >> N);
    end

endmodule

// File: rtl/rr_req_mux.sv
// rtl/rr_req_mux.sv - packet-locked round-robin N:1 request mux with registered output stage
module rr_req_mux
    import rr_req_mux_pkg::*;
#(
    parameter int N  = RR_N_DEF,
    parameter int W  = RR_W_DEF,
    parameter int SW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_valid_i,
    input  logic [N*W-1:0] req_data_i,
    input  logic [N-1:0]   req_last_i,
    output logic [N-1:0]   req_ready_o,
    output logic           out_valid_o,
    output logic [W-1:0]   out_data_o,
    output logic           out_last_o,
    output logic [SW-1:0]  out_src_o,
    input  logic           out_ready_i
);

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } sel_beat_t;

    lock_state_e   state_q, state_d;
    logic [SW-1:0] lock_src_q, lock_src_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] sel_idx;
    logic [N-1:0]  pick_grant;
    logic [N-1:0]  grant;
    logic          stage_free;
    logic          in_hs;
    sel_beat_t     sel_beat;

    rr_ptr_pick #(.N(N), .SW(SW)) u_pick (
        .valid (req_valid_i),
        .ptr   (ptr_q),
        .grant (pick_grant)
    );

    // While locked only the owning source may be granted, even if it idles.
    always_comb begin
        grant = '0;
        if (state_q == ST_LOCKED) begin
            grant[lock_src_q] = req_valid_i[lock_src_q];
        end else begin
            grant = pick_grant;
        end
    end

    assign stage_free  = ~out_valid_o | out_ready_i;
    assign req_ready_o = grant & {N{stage_free}};
    assign in_hs       = |(req_valid_i & req_ready_o);
    assign sel_idx     = SW'(oh_to_idx(RR_MAX_N'(grant)));
    assign sel_beat    = '{data: req_data_i[sel_idx*W +: W], last: req_last_i[sel_idx]};

    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        ptr_d      = ptr_q;
        if (in_hs) begin
            if (sel_beat.last) begin
                state_d = ST_IDLE;
                ptr_d   = (sel_idx == SW'(N - 1)) ? '0 : sel_idx + SW'(1);
            end else if (state_q == ST_IDLE) begin
                state_d    = ST_LOCKED;
                lock_src_d = sel_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            lock_src_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            ptr_q      <= ptr_d;
        end
    end

    // A load in the same cycle as a drain overwrites the stage, giving one beat per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_src_o   <= '0;
        end else if (in_hs) begin
            out_valid_o <= 1'b1;
            out_data_o  <= sel_beat.data;
            out_last_o  <= sel_beat.last;
            out_src_o   <= sel_idx;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_req_mux.sv
// tb/tb_rr_req_mux.sv - self-checking bench for rr_req_mux with a behavioural arbitration model
module tb_rr_req_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_src;
    logic           out_ready = 1'b0;

    always #5 clk = ~clk;

    rr_req_mux #(.N(N), .W(W), .SW(SW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_src_o   (out_src),
        .out_ready_i (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Model: next-priority source, owning source (-1 when free) and the output stage contents.
    int           m_ptr;
    int           m_lock;
    bit           m_v;
    logic [W-1:0] m_data;
    bit           m_last;
    int           m_src;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_lock = -1;
        m_v    = 0;
        m_data = '0;
        m_last = 0;
        m_src  = 0;
    endtask

    function automatic int model_grant();
        if (m_lock >= 0) return req_valid[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready(input logic ordy);
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0 && (!m_v || ordy)) r[g] = 1'b1;
        return r;
    endfunction

    // Called at a falling edge; returns at the next falling edge with the accepted source (-1 if none).
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*W-1:0] d,
                         input logic ordy, output int acc);
        logic [N-1:0] er;
        chk("out_valid", out_valid, m_v);
        chk("out_data", out_data, m_data);
        chk("out_last", out_last, m_last);
        chk("out_src", out_src, m_src);
        req_valid = v;
        req_last  = l;
        req_data  = d;
        out_ready = ordy;
        #1;
        er  = model_ready(ordy);
        acc = (er != 0) ? model_grant() : -1;
        chk("req_ready", req_ready, er);
        if (acc >= 0) begin
            m_v    = 1;
            m_data = d[acc*W +: W];
            m_last = l[acc];
            m_src  = acc;
            if (l[acc]) begin
                m_ptr  = (acc + 1) % N;
                m_lock = -1;
            end else begin
                m_lock = acc;
            end
        end else if (ordy) begin
            m_v = 0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [N-1:0] v);
        req_valid = v;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_req_ready", req_ready, model_ready(1'b1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        @(negedge clk);
        apply_reset('0);

        // Everyone valid with single-beat packets: strict rotation, no bubbles.
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b1, acc);
            chk("rot_grant", acc, exp_seq[i]);
        end

        // Source 2 three-beat packet while source 0 keeps requesting.
        cycle(4'b0101, 4'b0001, {8'h00, 8'hA0, 8'h00, 8'h01}, 1'b1, acc);
        chk("pkt2_b0", acc, 2);
        cycle(4'b0101, 4'b0001, {8'h00, 8'hA1, 8'h00, 8'h02}, 1'b1, acc);
        chk("pkt2_b1", acc, 2);
        cycle(4'b0101, 4'b0101, {8'h00, 8'hA2, 8'h00, 8'h03}, 1'b1, acc);
        chk("pkt2_b2", acc, 2);
        cycle(4'b0101, 4'b0101, {8'h00, 8'hA3, 8'h00, 8'h04}, 1'b1, acc);
        chk("after_pkt2", acc, 0);

        // Locked source 1 idles for two cycles; source 3 must not sneak in.
        cycle(4'b1010, 4'b0000, {8'h30, 8'h00, 8'hB0, 8'h00}, 1'b1, acc);
        chk("pkt1_b0", acc, 1);
        for (int i = 0; i < 2; i++) begin
            cycle(4'b1000, 4'b1000, {8'h30, 8'h00, 8'h00, 8'h00}, 1'b1, acc);
            chk("lock_gap", acc, -1);
        end
        cycle(4'b1010, 4'b0000, {8'h30, 8'h00, 8'hB1, 8'h00}, 1'b1, acc);
        chk("pkt1_b1", acc, 1);
        cycle(4'b1010, 4'b0010, {8'h30, 8'h00, 8'hB2, 8'h00}, 1'b1, acc);
        chk("pkt1_b2", acc, 1);
        cycle(4'b1000, 4'b1000, {8'h31, 8'h00, 8'h00, 8'h00}, 1'b1, acc);
        chk("after_pkt1", acc, 3);

        // Downstream stall with 0x5C held in the stage.
        cycle(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h5C}, 1'b1, acc);
        chk("stall_load", acc, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h11}, 1'b0, acc);
            chk("stall_hold", out_data, 8'h5C);
        end
        cycle(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h11}, 1'b1, acc);
        chk("stall_release", out_data, 8'h11);

        // Reset while source 1 is mid-packet.
        cycle(4'b0010, 4'b0000, {8'h00, 8'h00, 8'hC0, 8'h00}, 1'b1, acc);
        cycle(4'b0010, 4'b0000, {8'h00, 8'h00, 8'hC1, 8'h00}, 1'b1, acc);
        apply_reset(4'b0011);
        cycle(4'b0011, 4'b0011, {8'h00, 8'h00, 8'hD1, 8'hD0}, 1'b1, acc);
        chk("post_rst_grant", acc, 0);

        // Lone requester 3 streaming single-beat packets.
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1000, 4'b1000, {8'(8'hE0 + i), 24'h0}, 1'b1, acc);
            chk("solo3_grant", acc, 3);
        end

        for (int i = 0; i < 2000; i++) begin
            cycle(4'($urandom) | 4'($urandom), 4'($urandom), 32'($urandom),
                  ($urandom % 4) != 0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
